// File: rtl/apu_arb_pkg.sv
// apu_arb_pkg: shared widths for the APU arbiter slice
package apu_arb_pkg;
    localparam int REG_AW = 6;
    localparam int CNT_W  = 16;
endpackage

// File: rtl/riscv_apu_arb_idfifo.sv
// riscv_apu_arb_idfifo: in-order FIFO of granted requester IDs
module riscv_apu_arb_idfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= din;
    end
    assign head  = mem[rptr];
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/riscv_apu_arbiter.sv
// riscv_apu_arbiter: round-robin arbiter for a shared APU with in-order result routing.
// Define APU_ARB_PERF_EN to enable per-core saturating contention counters.
module riscv_apu_arbiter import apu_arb_pkg::*; #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0][REG_AW-1:0]   waddr_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               valid_o,
    output logic                             apu_req_o,
    output logic [REG_AW-1:0]                apu_waddr_o,
    input  logic                             apu_gnt_i,
    input  logic                             apu_valid_i,
    output logic                             apu_ready_o,
    output logic                             err_o,
    output logic [NUM_REQ-1:0][CNT_W-1:0]    cont_cnt_o
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] last_id, sel, head;
    logic full, empty, hs, bypass, push, pop;
    // Scan from the farthest candidate down so the nearest one after last_id wins
    always_comb begin
        sel = last_id;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_i[IW'((int'(last_id) + k) % NUM_REQ)]) sel = IW'((int'(last_id) + k) % NUM_REQ);
    end
    assign apu_req_o   = |req_i & !full;
    assign apu_waddr_o = waddr_i[sel];
    assign apu_ready_o = 1'b1;
    assign hs          = apu_req_o & apu_gnt_i;
    assign gnt_o       = hs ? NUM_REQ'(1) << sel : '0;
    assign bypass      = hs & apu_valid_i & empty;
    assign push        = hs & !bypass;
    assign pop         = apu_valid_i & !empty;
    assign valid_o     = pop ? NUM_REQ'(1) << head : bypass ? NUM_REQ'(1) << sel : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_id <= IW'(NUM_REQ - 1);
            err_o   <= 1'b0;
        end else begin
            if (hs) last_id <= sel;
            if (apu_valid_i & empty & !hs) err_o <= 1'b1;
        end
    end
    riscv_apu_arb_idfifo #(.DEPTH(MAX_OUTST), .W(IW)) u_idfifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push(push),
        .pop(pop),
        .din(sel),
        .head(head),
        .full(full),
        .empty(empty)
    );
`ifdef APU_ARB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (req_i[i] & !gnt_o[i] & ~&cnt[i]) cnt[i] <= cnt[i] + 1'b1;
    end
    assign cont_cnt_o = cnt;
`else
    assign cont_cnt_o = '0;
`endif
endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// tb_riscv_apu_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_riscv_apu_arbiter;
    localparam int N = 4;
    localparam int M = 4;
    logic              clk_i = 0;
    logic              rst_i = 1;
    logic [N-1:0]      req_i = '0;
    logic [N-1:0][5:0] waddr_i = '0;
    logic [N-1:0]      gnt_o, valid_o;
    logic              apu_req_o, apu_gnt_i = 0, apu_valid_i = 0, apu_ready_o, err_o;
    logic [5:0]        apu_waddr_o;
    logic [N-1:0][15:0] cont_cnt_o;
    int checks = 0, errors = 0;
    int m_last;
    int m_q[$];
    bit m_err;
    int m_cnt[N];
    int exp_sel;
    bit exp_apu_req, exp_hs;
    logic [N-1:0] exp_gnt, exp_valid;

    riscv_apu_arbiter #(.NUM_REQ(N), .MAX_OUTST(M)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .waddr_i(waddr_i),
        .gnt_o(gnt_o), .valid_o(valid_o), .apu_req_o(apu_req_o),
        .apu_waddr_o(apu_waddr_o), .apu_gnt_i(apu_gnt_i), .apu_valid_i(apu_valid_i),
        .apu_ready_o(apu_ready_o), .err_o(err_o), .cont_cnt_o(cont_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_last = N - 1;
        m_q = {};
        m_err = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic eval();
        exp_sel = 0;
        for (int k = N; k >= 1; k--) if (req_i[(m_last + k) % N]) exp_sel = (m_last + k) % N;
        exp_apu_req = (req_i != 0) && (m_q.size() < M);
        exp_hs = exp_apu_req && apu_gnt_i;
        exp_gnt = exp_hs ? N'(1 << exp_sel) : '0;
        exp_valid = !apu_valid_i ? '0 : m_q.size() > 0 ? N'(1 << m_q[0]) : exp_hs ? N'(1 << exp_sel) : '0;
    endtask

    task automatic apply(input logic [N-1:0] r, input bit g, input bit v);
        req_i = r;
        apu_gnt_i = g;
        apu_valid_i = v;
        for (int i = 0; i < N; i++) waddr_i[i] = 6'($urandom);
        eval();
        #1;
    endtask

    task automatic tick();
        int sz;
        @(posedge clk_i);
        sz = m_q.size();
        for (int i = 0; i < N; i++) if (req_i[i] && !exp_gnt[i] && m_cnt[i] < 65535) m_cnt[i]++;
        if (apu_valid_i) begin
            if (sz > 0) void'(m_q.pop_front());
            else if (!exp_hs) m_err = 1;
        end
        if (exp_hs) begin
            if (!(apu_valid_i && sz == 0)) m_q.push_back(exp_sel);
            m_last = exp_sel;
        end
        #1;
    endtask

    task automatic do_reset();
        req_i = '0; apu_gnt_i = 0; apu_valid_i = 0;
        rst_i = 1;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 0;
    endtask

    task automatic test_reset();
        req_i = '0; apu_gnt_i = 0; apu_valid_i = 1;
        rst_i = 1;
        model_reset();
        #2;
        checks++;
        if ({apu_req_o, gnt_o, valid_o, err_o} !== '0 || apu_ready_o !== 1'b1 || cont_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset: req=%b gnt=%b valid=%b err=%b ready=%b cnt=%h, need all 0 and ready 1",
                     apu_req_o, gnt_o, valid_o, err_o, apu_ready_o, cont_cnt_o);
        end
        @(posedge clk_i);
        #1;
        apu_valid_i = 0;
        rst_i = 0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(4'b1111, 1, 0);
            checks++;
            if (gnt_o !== want[c] || apu_waddr_o !== waddr_i[c]) begin
                errors++;
                $display("FAIL rr_cycle%0d: gnt=%b waddr=%0d, need gnt=%b waddr=%0d", c, gnt_o, apu_waddr_o, want[c], waddr_i[c]);
            end
            tick();
        end
    endtask

    task automatic test_no_accept();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(4'b0101, 0, 0);
            checks++;
            if (apu_req_o !== 1'b1 || gnt_o !== '0) begin
                errors++;
                $display("FAIL noacc_cycle%0d: apu_req=%b gnt=%b, need 1 and 0000", c, apu_req_o, gnt_o);
            end
            tick();
        end
        checks++;
`ifdef APU_ARB_PERF_EN
        if (cont_cnt_o[0] !== 16'd3 || cont_cnt_o[2] !== 16'd3 || cont_cnt_o[1] !== 16'd0) begin
`else
        if (cont_cnt_o !== '0) begin
`endif
            errors++;
            $display("FAIL noacc_cnt: cnt=%h", cont_cnt_o);
        end
        apply(4'b0101, 1, 0);
        checks++;
        if (gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL noacc_last_id: gnt=%b, need 0001", gnt_o);
        end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(4'b1111, 1, 0);
            tick();
        end
        apply(4'b1111, 1, 0);
        checks++;
        if (apu_req_o !== 1'b0 || gnt_o !== '0) begin
            errors++;
            $display("FAIL full_block: apu_req=%b gnt=%b, need 0 and 0000", apu_req_o, gnt_o);
        end
        tick();
        apply(4'b1111, 1, 1);
        checks++;
        if (valid_o !== 4'b0001 || gnt_o !== '0) begin
            errors++;
            $display("FAIL full_pop: valid=%b gnt=%b, need 0001 and 0000", valid_o, gnt_o);
        end
        tick();
        apply(4'b1111, 1, 0);
        checks++;
        if (gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL full_resume: gnt=%b, need 0001", gnt_o);
        end
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        apply(4'b0100, 1, 1);
        checks++;
        if (gnt_o !== 4'b0100 || valid_o !== 4'b0100) begin
            errors++;
            $display("FAIL bypass: gnt=%b valid=%b, need 0100 0100", gnt_o, valid_o);
        end
        tick();
        apply(4'b0000, 0, 1);
        checks++;
        if (valid_o !== '0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_empty: valid=%b err=%b, need 0000 0", valid_o, err_o);
        end
        tick();
    endtask

    task automatic test_err();
        do_reset();
        apply(4'b0000, 0, 1);
        checks++;
        if (valid_o !== '0) begin
            errors++;
            $display("FAIL err_valid: valid=%b, need 0000", valid_o);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(4'b0000, 0, 0);
            checks++;
            if (err_o !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky%0d: err=%b, need 1", c, err_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(4'b0000, 0, 1);
        tick();
        for (int c = 0; c < 2; c++) begin
            apply(4'b1111, 1, 0);
            tick();
        end
        do_reset();
        apply(4'b1111, 1, 0);
        checks++;
        if (err_o !== 1'b0 || gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_grant: err=%b gnt=%b, need 0 0001", err_o, gnt_o);
        end
        tick();
        apply(4'b0000, 0, 1);
        checks++;
        if (valid_o !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_pop: valid=%b, need 0001", valid_o);
        end
        tick();
        apply(4'b0000, 0, 1);
        checks++;
        if (valid_o !== '0) begin
            errors++;
            $display("FAIL rstmid_empty: valid=%b, need 0000", valid_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_err: err=%b, need 1", err_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            apply(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            checks++;
            if (apu_req_o !== exp_apu_req || gnt_o !== exp_gnt || valid_o !== exp_valid || err_o !== m_err
                || (exp_apu_req && apu_waddr_o !== waddr_i[exp_sel])) begin
                errors++;
                $display("FAIL rand%0d: req=%b gnt=%b valid=%b err=%b waddr=%0d, need %b %b %b %b %0d",
                         c, apu_req_o, gnt_o, valid_o, err_o, apu_waddr_o,
                         exp_apu_req, exp_gnt, exp_valid, m_err, waddr_i[exp_sel]);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
`ifdef APU_ARB_PERF_EN
                if (cont_cnt_o[i] !== 16'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL rand%0d_cnt%0d: got %0d, need %0d", c, i, cont_cnt_o[i], m_cnt[i]);
                end
`else
                if (cont_cnt_o[i] !== 16'd0) begin
                    errors++;
                    $display("FAIL rand%0d_cnt%0d: got %0d, need 0", c, i, cont_cnt_o[i]);
                end
`endif
            end
            tick();
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_round_robin();
        test_no_accept();
        test_full();
        test_bypass();
        test_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
